// File: rtl/conv_pkg.sv
// Shared definitions for the ConvCode encoder/decoder chain.
// States, rate-mode codes and the generator parity helper.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IN,
        S_OUT0,
        S_OUT1,
        S_TAIL
    } state_e;

    localparam logic RATE_1_2 = 1'b0;
    localparam logic RATE_2_3 = 1'b1;

    // Widest supported window (K up to 9).
    localparam int KMAX = 9;

    function automatic logic parity(
        input logic [KMAX-1:0] w,
        input logic [KMAX-1:0] g
    );
        return ^(w & g);
    endfunction

endpackage

// File: rtl/conv_encoder_p.sv
// Parametrised convolutional encoder, rate 1/2 or punctured 2/3,
// with K-1 zero tail bits per frame and valid/ready on both sides.
module conv_encoder_p
    import conv_pkg::*;
#(
    parameter int             K  = 3,
    parameter logic [K-1:0]   G0 = K'(3'b111),
    parameter logic [K-1:0]   G1 = K'(3'b101)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic punct,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_data,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_data,
    output logic out_last,
    output logic busy
);

    localparam int TW = 4;

    state_e          state_q, state_d;
    logic [K-2:0]    sr_q, sr_d;
    logic [TW-1:0]   tail_cnt_q, tail_cnt_d;
    logic            c0_q, c0_d;
    logic            c1_q, c1_d;
    logic            last_q, last_d;
    logic            tail_q, tail_d;
    logic            phase_q, phase_d;
    logic            punct_q, punct_d;
    logic            busy_q, busy_d;
    logic            in_ready_q, in_ready_d;

    logic [K-1:0]    win;
    logic            sym_punct;
    logic            end_sym;

    // Odd symbols of a punctured frame carry c0 only.
    assign sym_punct = (punct_q == RATE_2_3) && phase_q;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        tail_cnt_d = tail_cnt_q;
        c0_d       = c0_q;
        c1_d       = c1_q;
        last_d     = last_q;
        tail_d     = tail_q;
        phase_d    = phase_q;
        punct_d    = punct_q;
        busy_d     = busy_q;
        win        = {1'b0, sr_q};
        end_sym    = 1'b0;

        unique case (state_q)
            S_IN: begin
                if (in_valid) begin
                    if (!busy_q) begin
                        punct_d = punct;
                        busy_d  = 1'b1;
                    end
                    win     = {in_data, sr_q};
                    c0_d    = parity(KMAX'(win), KMAX'(G0));
                    c1_d    = parity(KMAX'(win), KMAX'(G1));
                    sr_d    = {in_data, sr_q[K-2:1]};
                    last_d  = in_last;
                    state_d = S_OUT0;
                end
            end
            S_TAIL: begin
                win        = {1'b0, sr_q};
                c0_d       = parity(KMAX'(win), KMAX'(G0));
                c1_d       = parity(KMAX'(win), KMAX'(G1));
                sr_d       = {1'b0, sr_q[K-2:1]};
                tail_cnt_d = tail_cnt_q - 1'b1;
                state_d    = S_OUT0;
            end
            S_OUT0: begin
                if (out_ready) begin
                    if (sym_punct) end_sym = 1'b1;
                    else           state_d = S_OUT1;
                end
            end
            S_OUT1: begin
                if (out_ready) end_sym = 1'b1;
            end
        endcase

        if (end_sym) begin
            phase_d = ~phase_q;
            if (last_q) begin
                last_d     = 1'b0;
                tail_d     = 1'b1;
                tail_cnt_d = TW'(K - 1);
                state_d    = S_TAIL;
            end else if (tail_q && tail_cnt_q != '0) begin
                state_d = S_TAIL;
            end else begin
                state_d = S_IN;
                if (tail_q) begin
                    tail_d  = 1'b0;
                    phase_d = 1'b0;
                    punct_d = RATE_1_2;
                    busy_d  = 1'b0;
                end
            end
        end
    end

    assign in_ready_d = (state_d == S_IN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IN;
            sr_q       <= '0;
            tail_cnt_q <= '0;
            c0_q       <= 1'b0;
            c1_q       <= 1'b0;
            last_q     <= 1'b0;
            tail_q     <= 1'b0;
            phase_q    <= 1'b0;
            punct_q    <= RATE_1_2;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            tail_cnt_q <= tail_cnt_d;
            c0_q       <= c0_d;
            c1_q       <= c1_d;
            last_q     <= last_d;
            tail_q     <= tail_d;
            phase_q    <= phase_d;
            punct_q    <= punct_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = (state_q == S_OUT0) || (state_q == S_OUT1);
    assign out_data  = ((state_q == S_OUT0) && c0_q) ||
                       ((state_q == S_OUT1) && c1_q);
    // Final coded bit of the last tail symbol, punctured or not.
    assign out_last  = tail_q && (tail_cnt_q == '0) &&
                       ((state_q == S_OUT1) ||
                        ((state_q == S_OUT0) && sym_punct));

endmodule

// File: tb/tb_conv_encoder_p.sv
// Randomised bench for conv_encoder_p against a tap-sum reference model.
// Two instances: K=3 (7,5) and K=5 (23,35 octal), sharing the stimulus.
module tb_conv_encoder_p;

    typedef bit bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic punct = 1'b0;
    logic in_valid = 1'b0;
    logic in_data = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic [1:0] ir, ov, od, ol, by;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #25 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_encoder_p dut0 (
        .clk(clk), .rst_n(rst_n), .punct(punct),
        .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_last(in_last),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_last(ol[0]), .busy(by[0])
    );

    conv_encoder_p #(.K(5), .G0(5'b10011), .G1(5'b11101)) dut1 (
        .clk(clk), .rst_n(rst_n), .punct(punct),
        .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_last(in_last),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_last(ol[1]), .busy(by[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output bit t is the XOR of generator-selected inputs x[t-j].
    function automatic void model(input bq_t d, input int k,
                                  input int g0, input int g1,
                                  input bit p, output bq_t o);
        bq_t x;
        bit c0, c1;
        x = d;
        repeat (k - 1) x.push_back(1'b0);
        o = {};
        for (int t = 0; t < x.size(); t++) begin
            c0 = 1'b0;
            c1 = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (t - j >= 0) begin
                    c0 ^= x[t-j] & g0[k-1-j];
                    c1 ^= x[t-j] & g1[k-1-j];
                end
            end
            o.push_back(c0);
            if (!(p && (t % 2 == 1))) o.push_back(c1);
        end
    endfunction

    task automatic reset_dut(input int sel);
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        punct = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", ir[sel], 1);
        check("rst_out_valid", ov[sel], 0);
        check("rst_out_data", od[sel], 0);
        check("rst_out_last", ol[sel], 0);
        check("rst_busy", by[sel], 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // mode: 0 out_ready high, 1 five-cycle stall on every second bit,
    // 2 random stalls. Starts and ends on a falling edge.
    task automatic run_frame(input int sel, input bq_t bits, input bit p,
                             input bq_t exp, input int mode,
                             input bit tog, input bit hold);
        fork
            begin : prod
                int g;
                int prev;
                prev = 0;
                for (int i = 0; i < bits.size(); i++) begin
                    in_valid = 1'b1;
                    in_data = bits[i];
                    in_last = (i == bits.size() - 1);
                    if (i == 0) punct = p;
                    g = 0;
                    while (ir[sel] !== 1'b1 && g < 500) begin
                        @(negedge clk);
                        g++;
                    end
                    if (g >= 500) begin
                        check("prod_timeout", 0, 1);
                        break;
                    end
                    if (mode == 0 && !p && i > 0)
                        check("accept_interval", cyc - prev, 3);
                    prev = cyc;
                    @(negedge clk);
                    if (i == 0) begin
                        check("latency", ov[sel], 1);
                        if (tog) punct = ~p;
                    end
                end
                if (!hold) begin
                    in_valid = 1'b0;
                    in_last = 1'b0;
                end
            end
            begin : cons
                int idx, g, n, sl;
                bit done;
                logic hd, hl;
                idx = 0;
                g = 0;
                done = 1'b0;
                n = exp.size();
                out_ready = (mode == 0);
                while (!done && g < 3000) begin
                    if (ov[sel] === 1'b1) begin
                        check("in_ready_low", ir[sel], 0);
                        check("busy_high", by[sel], 1);
                        sl = 0;
                        if (mode == 1 && idx % 2 == 1) sl = 5;
                        if (mode == 2 && $urandom_range(0, 2) == 0)
                            sl = $urandom_range(1, 6);
                        if (sl > 0) begin
                            out_ready = 1'b0;
                            hd = od[sel];
                            hl = ol[sel];
                            repeat (sl) begin
                                @(negedge clk);
                                g++;
                                check("stall_valid", ov[sel], 1);
                                check("stall_data", od[sel], hd);
                                check("stall_last", ol[sel], hl);
                            end
                        end
                        out_ready = 1'b1;
                        check($sformatf("bit%0d", idx), od[sel],
                              idx < n ? int'(exp[idx]) : 2);
                        check($sformatf("last%0d", idx), ol[sel],
                              int'(idx == n - 1));
                        done = ol[sel];
                        idx++;
                    end else if (mode != 0) begin
                        out_ready = 1'($urandom_range(0, 1));
                    end
                    @(negedge clk);
                    g++;
                end
                if (!done) check("cons_timeout", 0, 1);
                check("n_bits", idx, n);
                check("busy_fall", by[sel], 0);
                check("in_ready_back", ir[sel], 1);
            end
        join
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t b, e, s1, s2;
        int cnt, g, len;
        bit p;

        s1 = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1};
        s2 = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        b = '{1, 0, 1, 1};

        @(negedge clk);
        reset_dut(0);

        run_frame(0, b, 1'b0, s1, 0, 1'b0, 1'b0);
        run_frame(0, b, 1'b1, s2, 0, 1'b0, 1'b0);
        run_frame(0, b, 1'b0, s1, 1, 1'b0, 1'b0);

        // Abort a frame after two coded bits.
        punct = 1'b0;
        in_valid = 1'b1;
        in_data = 1'b1;
        in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        g = 0;
        while (cnt < 2 && g < 50) begin
            if (ov[0]) cnt++;
            @(negedge clk);
            g++;
        end
        check("pre_reset_bits", cnt, 2);
        check("busy_mid", by[0], 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", ov[0], 0);
        check("mid_rst_ready", ir[0], 1);
        check("mid_rst_busy", by[0], 0);
        @(negedge clk);
        check("mid_rst_valid2", ov[0], 0);
        check("mid_rst_ready2", ir[0], 1);
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        run_frame(0, b, 1'b0, s1, 0, 1'b0, 1'b0);

        // punct flips mid-frame; in_valid stays up into the next frame.
        run_frame(0, b, 1'b1, s2, 0, 1'b1, 1'b1);
        b = '{1};
        model(b, 3, 7, 5, 1'b0, e);
        run_frame(0, b, 1'b0, e, 0, 1'b0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 10);
            p = 1'($urandom_range(0, 1));
            b = {};
            repeat (len) b.push_back(1'($urandom_range(0, 1)));
            model(b, 3, 7, 5, p, e);
            run_frame(0, b, p, e, 2, 1'b0, 1'b0);
        end

        reset_dut(1);
        b = '{1};
        model(b, 5, 19, 29, 1'b0, e);
        check("k5_len", e.size(), 10);
        run_frame(1, b, 1'b0, e, 0, 1'b0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            len = $urandom_range(1, 12);
            p = 1'($urandom_range(0, 1));
            b = {};
            repeat (len) b.push_back(1'($urandom_range(0, 1)));
            model(b, 5, 19, 29, p, e);
            run_frame(1, b, p, e, 2, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
